// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: start strobe, ROM read port, issue handshake towards the CU and status.
// The master modport is the fetch unit; the slave modport is the ROM/CU environment.
`timescale 1ns / 1ps
interface instr_fetch_if;
   logic        start;
   logic [7:0]  rom_address;
   logic        rom_read_enable;
   logic [15:0] rom_data;
   logic [3:0]  opcode;
   logic [5:0]  dest;
   logic [5:0]  src;
   logic        instr_valid;
   logic        instr_ready;
   logic [7:0]  pc;
   logic        halted;

   modport master (
      input  start, rom_data, instr_ready,
      output rom_address, rom_read_enable, opcode, dest, src, instr_valid, pc, halted
   );

   modport slave (
      output start, rom_data, instr_ready,
      input  rom_address, rom_read_enable, opcode, dest, src, instr_valid, pc, halted
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads 16-bit words from a one-cycle-latency ROM, stops on HALT
// (opcode 4'hF) and issues everything else to the CU over a valid/ready handshake.
// Optional feature: define FETCH_JUMP_EN to resolve JMP (opcode 4'hD) inside the fetch unit;
// the jump target is the low byte of the instruction and the JMP itself is never issued.
`timescale 1ns / 1ps
module instr_fetch (
   input  logic              clk,
   input  logic              rst,
   instr_fetch_if.master     bus
);

   localparam logic [3:0] OpHalt = 4'b1111;
`ifdef FETCH_JUMP_EN
   localparam logic [3:0] OpJmp  = 4'b1101;
`endif

   typedef enum logic [2:0] {StIdle, StFetch, StWait, StIssue, StHalt} state_e;

   state_e      state_q, state_d;
   logic [7:0]  pc_q, pc_d;
   logic [15:0] ir_q, ir_d;

   // State, program counter and instruction register; reset wins over every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         pc_q    <= 8'h00;
         ir_q    <= 16'h0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // Next-state logic: the ROM word is only looked at in WAIT, one cycle after the strobe.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         StIdle:  if (bus.start) state_d = StFetch;
         StFetch: state_d = StWait;
         StWait: begin
            ir_d = bus.rom_data;
            pc_d = pc_q + 8'd1;  // wraps 8'hFF -> 8'h00 naturally
            if (bus.rom_data[15:12] == OpHalt) begin
               state_d = StHalt;
`ifdef FETCH_JUMP_EN
            end else if (bus.rom_data[15:12] == OpJmp) begin
               pc_d    = bus.rom_data[7:0];
               state_d = StFetch;
`endif
            end else begin
               state_d = StIssue;
            end
         end
         StIssue: if (bus.instr_ready) state_d = StFetch;
         StHalt:  state_d = StHalt;  // only rst leaves HALT
         default: state_d = StIdle;
      endcase
   end

   // Moore outputs: decoded from the state register only, fields from the latched word.
   always_comb begin
      bus.rom_read_enable = (state_q == StFetch);
      bus.rom_address     = (state_q == StFetch) ? pc_q : 8'h00;
      bus.instr_valid     = (state_q == StIssue);
      bus.halted          = (state_q == StHalt);
      bus.opcode          = ir_q[15:12];
      bus.dest            = ir_q[11:6];
      bus.src             = ir_q[5:0];
      bus.pc              = pc_q;
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural one-cycle ROM, monitor that logs fetches and accepted
// issues, and a scoreboard of expected issued instructions filled by each scenario.
`timescale 1ns / 1ps
module tb_instr_fetch;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instr_fetch_if bus ();

   instr_fetch dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [15:0] rom [256];
   logic [15:0] exp_q [$];
   logic [15:0] got_q [$];
   int          got_cyc [$];
   logic [7:0]  fetch_q [$];
   int          fetch_cyc [$];
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   // ROM answers one cycle after the strobe; junk on the bus otherwise
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.rom_read_enable) bus.rom_data <= rom[bus.rom_address];
      else                     bus.rom_data <= 16'hBEEF;
   end

   // Monitor at the falling edge, where inputs and outputs are settled for the next edge
   always @(negedge clk) begin
      if (!rst && bus.instr_valid && bus.instr_ready) begin
         got_q.push_back({bus.opcode, bus.dest, bus.src});
         got_cyc.push_back(cyc);
      end
      if (!rst && bus.rom_read_enable) begin
         fetch_q.push_back(bus.rom_address);
         fetch_cyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      bus.instr_ready = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      tick();
      tick();
      exp_q.delete(); got_q.delete(); got_cyc.delete();
      fetch_q.delete(); fetch_cyc.delete();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if ({bus.instr_valid, bus.halted, bus.rom_read_enable, bus.rom_address, bus.pc} !== 19'd0)
      begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%b halted=%b re=%b addr=%h pc=%h, want all 0",
                  bus.instr_valid, bus.halted, bus.rom_read_enable, bus.rom_address, bus.pc);
      end
      n_tests++;
      if ({bus.opcode, bus.dest, bus.src} !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_ir: got %h, want 0000", {bus.opcode, bus.dest, bus.src});
      end
      // idle without start, ready ignored
      bus.instr_ready = 1'b1;
      repeat (3) tick();
      n_tests++;
      if (fetch_q.size() !== 0 || bus.rom_read_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_no_fetch: fetches=%0d re=%b, want 0 0", fetch_q.size(),
                  bus.rom_read_enable);
      end
      // reset in the middle of a fetch: the returning ROM word must be dropped
      rom[0] = 16'h1042;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (3) tick();
      n_tests++;
      if ({bus.instr_valid, bus.opcode, bus.pc} !== 13'd0 || got_q.size() !== 0) begin
         n_fail++;
         $display("FAIL reset_mid_fetch: valid=%b op=%h pc=%h issues=%0d, want 0 0 00 0",
                  bus.instr_valid, bus.opcode, bus.pc, got_q.size());
      end
   endtask

   task automatic test_mov_halt();
      logic [15:0] e;
      do_reset();
      rom[0] = 16'h1042;
      rom[1] = 16'hF000;
      exp_q.push_back({4'h1, 6'd1, 6'd2});
      bus.instr_ready = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 30 && !bus.halted; i++) tick();
      n_tests++;
      if (bus.halted !== 1'b1 || bus.pc !== 8'h02 || bus.instr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mov_halt_state: halted=%b pc=%h valid=%b, want 1 02 0", bus.halted,
                  bus.pc, bus.instr_valid);
      end
      n_tests++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL mov_issue_count: got %0d, want %0d", got_q.size(), exp_q.size());
      end else begin
         e = exp_q.pop_front();
         n_tests++;
         if (got_q[0] !== e) begin
            n_fail++;
            $display("FAIL mov_issue_value: got %h, want %h", got_q[0], e);
         end
         n_tests++;
         if (got_cyc[0] - fetch_cyc[0] !== 2) begin
            n_fail++;
            $display("FAIL fetch_to_issue_latency: got %0d, want 2", got_cyc[0] - fetch_cyc[0]);
         end
      end
      // start is ignored while halted
      bus.start = 1'b1;
      repeat (2) tick();
      bus.start = 1'b0;
      repeat (3) tick();
      n_tests++;
      if (bus.halted !== 1'b1 || fetch_q.size() !== 2 || got_q.size() !== 1) begin
         n_fail++;
         $display("FAIL halt_absorbing: halted=%b fetches=%0d issues=%0d, want 1 2 1",
                  bus.halted, fetch_q.size(), got_q.size());
      end
   endtask

   task automatic test_backpressure();
      int f;
      do_reset();
      rom[0] = 16'h2083;
      rom[1] = 16'hF000;
      exp_q.push_back({4'h2, 6'd2, 6'd3});
      bus.start = 1'b1;
      tick();
      // start kept high outside IDLE must have no effect
      for (int i = 0; i < 10 && !bus.instr_valid; i++) tick();
      n_tests++;
      if (bus.instr_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_issue_timeout: valid=%b, want 1", bus.instr_valid);
      end
      f = fetch_q.size();
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if (bus.instr_valid !== 1'b1 || {bus.opcode, bus.dest, bus.src} !== 16'h2083
             || bus.rom_read_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: valid=%b instr=%h re=%b, want 1 2083 0", i,
                     bus.instr_valid, {bus.opcode, bus.dest, bus.src}, bus.rom_read_enable);
         end
         tick();
      end
      n_tests++;
      if (fetch_q.size() !== f) begin
         n_fail++;
         $display("FAIL bp_early_fetch: fetches=%0d, want %0d", fetch_q.size(), f);
      end
      bus.start = 1'b0;
      bus.instr_ready = 1'b1;
      tick();
      bus.instr_ready = 1'b0;
      n_tests++;
      if (bus.rom_read_enable !== 1'b1 || bus.rom_address !== 8'h01 || bus.instr_valid !== 1'b0)
      begin
         n_fail++;
         $display("FAIL bp_fetch_after_ready: re=%b addr=%h valid=%b, want 1 01 0",
                  bus.rom_read_enable, bus.rom_address, bus.instr_valid);
      end
      repeat (4) tick();
      n_tests++;
      if (got_q.size() !== 1 || got_q[0] !== exp_q[0] || bus.halted !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_scoreboard: issues=%0d halted=%b, want 1 issue of %h and halted=1",
                  got_q.size(), bus.halted, exp_q[0]);
      end
   endtask

   task automatic test_pc_wrap();
      int bad;
      int slow;
      do_reset();
      for (int i = 0; i < 256; i++) exp_q.push_back(16'h0000);
      bus.instr_ready = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 900 && fetch_q.size() < 257; i++) tick();
      n_tests++;
      if (fetch_q.size() < 257) begin
         n_fail++;
         $display("FAIL wrap_timeout: fetches=%0d, want 257", fetch_q.size());
      end else begin
         n_tests++;
         if (fetch_q[255] !== 8'hFF || fetch_q[256] !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap_address: got %h then %h, want ff then 00", fetch_q[255],
                     fetch_q[256]);
         end
      end
      n_tests++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL wrap_issue_count: got %0d, want %0d", got_q.size(), exp_q.size());
      end else begin
         bad = 0;
         slow = 0;
         for (int i = 0; i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) bad++;
            if (i > 0 && got_cyc[i] - got_cyc[i-1] != 3) slow++;
         end
         n_tests++;
         if (bad !== 0) begin
            n_fail++;
            $display("FAIL wrap_issue_values: %0d wrong, want 0", bad);
         end
         n_tests++;
         if (slow !== 0) begin
            n_fail++;
            $display("FAIL issue_rate: %0d gaps not 3 cycles, want 0", slow);
         end
      end
   endtask

   task automatic test_reset_mid_issue();
      int found;
      int bad;
      do_reset();
      for (int i = 0; i < 5; i++) rom[i] = 16'h3000 | 16'(i << 6) | 16'(i);
      for (int i = 0; i < 4; i++) exp_q.push_back(rom[i]);
      bus.instr_ready = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      found = 0;
      for (int i = 0; i < 40 && found == 0; i++) begin
         if (bus.instr_valid && bus.pc == 8'h05) found = 1;
         else tick();
      end
      n_tests++;
      if (found !== 1) begin
         n_fail++;
         $display("FAIL rst_issue_timeout: pc=%h valid=%b, want 05 1", bus.pc, bus.instr_valid);
      end
      rst = 1'b1;  // together with instr_ready=1: reset must win
      tick();
      rst = 1'b0;
      n_tests++;
      if ({bus.instr_valid, bus.halted, bus.rom_read_enable, bus.pc, bus.opcode} !== 15'd0)
      begin
         n_fail++;
         $display("FAIL rst_in_issue: valid=%b halted=%b re=%b pc=%h op=%h, want all 0",
                  bus.instr_valid, bus.halted, bus.rom_read_enable, bus.pc, bus.opcode);
      end
      repeat (5) tick();
      n_tests++;
      if (got_q.size() !== exp_q.size() || fetch_q.size() !== 5 || bus.instr_valid !== 1'b0)
      begin
         n_fail++;
         $display("FAIL rst_no_issue: issues=%0d fetches=%0d valid=%b, want %0d 5 0",
                  got_q.size(), fetch_q.size(), bus.instr_valid, exp_q.size());
      end else begin
         bad = 0;
         while (exp_q.size() > 0) if (got_q.pop_front() !== exp_q.pop_front()) bad++;
         n_tests++;
         if (bad !== 0) begin
            n_fail++;
            $display("FAIL rst_issue_values: %0d wrong, want 0", bad);
         end
      end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n_tests++;
      if (bus.rom_read_enable !== 1'b1 || bus.rom_address !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_restart: re=%b addr=%h, want 1 00", bus.rom_read_enable,
                  bus.rom_address);
      end
   endtask

   task automatic test_jump();
      logic [7:0] exp_next;
      do_reset();
      rom[0]    = 16'hD010;
      rom[1]    = 16'hF000;
      rom[8'h10] = 16'hF000;
`ifdef FETCH_JUMP_EN
      exp_next = 8'h10;
`else
      exp_next = 8'h01;
      exp_q.push_back(16'hD010);
`endif
      bus.instr_ready = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 30 && !bus.halted; i++) tick();
      n_tests++;
      if (fetch_q.size() !== 2 || fetch_q[1] !== exp_next) begin
         n_fail++;
         $display("FAIL jump_next_address: fetches=%0d next=%h, want 2 %h", fetch_q.size(),
                  (fetch_q.size() > 1) ? fetch_q[1] : 8'hxx, exp_next);
      end
      n_tests++;
      if (got_q.size() !== exp_q.size() || (exp_q.size() == 1 && got_q[0] !== exp_q[0])) begin
         n_fail++;
         $display("FAIL jump_issue: issues=%0d, want %0d (D010 issued only without jump)",
                  got_q.size(), exp_q.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.instr_ready = 1'b0;
      test_reset();
      test_mov_halt();
      test_backpressure();
      test_pc_wrap();
      test_reset_mid_issue();
      test_jump();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
